// File: rtl/adc_max11331_scan_sched.sv
// MAX11331 scan scheduler: timer/ext trigger, ascending channel walk, tagged results (optional ID check: ADC_MAX11331_CHID_CHECK_EN).
// Latency: trigger->conv_start 1 cycle; conv_done->res_valid 1 cycle; next conv_start 3 cycles after conv_done.
// Backpressure: none on results; waits indefinitely on conv_done; triggers while busy are dropped and flagged in overrun.
module adc_max11331_scan_sched #(
    parameter int CNT_W = 32,
    parameter int NCH   = 16
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             enable,
    input  logic             use_ext_trig,
    input  logic             ext_trig,
    input  logic [CNT_W-1:0] period,
    input  logic [15:0]      chan_mask,
    input  logic             overrun_clr,
    output logic             conv_start,
    output logic [3:0]       conv_chan,
    input  logic             conv_done,
    input  logic [15:0]      conv_data,
    output logic             res_valid,
    output logic [3:0]       res_chan,
    output logic [11:0]      res_data,
    output logic             scan_done,
    output logic             busy,
    output logic             overrun
`ifdef ADC_MAX11331_CHID_CHECK_EN
    ,
    output logic             chid_err
`endif
);
    typedef enum logic [2:0] {IDLE, START, WAIT, STORE, NEXT} state_t;

    localparam logic [15:0] CH_VALID = (NCH >= 16) ? 16'hFFFF : 16'((32'd1 << NCH) - 32'd1);

    state_t           state;
    logic [15:0]      scan_mask;
    logic [3:0]       ch;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] per_cur;
    logic             run;
    logic             tc;
    logic             trig;
    logic [15:0]      start_mask;
    logic [15:0]      rem_mask;

    function automatic logic [3:0] lowest_bit(input logic [15:0] m);
        lowest_bit = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) lowest_bit = 4'(i);
        end
    endfunction

    // A new period is only picked up when the count is at zero, so changes land on a wrap.
    assign run        = enable && (period != '0);
    assign per_cur    = (cnt == '0) ? period : per_q;
    assign tc         = run && (per_cur != '0) && (cnt == per_cur - CNT_W'(1));
    assign trig       = use_ext_trig ? ext_trig : tc;
    assign start_mask = chan_mask & CH_VALID;
    assign rem_mask   = scan_mask & ~(16'd1 << ch);
    assign busy       = (state != IDLE);

`ifndef ADC_MAX11331_CHID_CHECK_EN
    logic unused_chid;
    assign unused_chid = ^conv_data[15:12];
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt   <= '0;
            per_q <= '0;
        end else if (!run) begin
            cnt   <= '0;
            per_q <= period;
        end else begin
            if (cnt == '0) per_q <= period;
            cnt <= tc ? '0 : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)              overrun <= 1'b0;
        else if (trig && busy)   overrun <= 1'b1;
        else if (overrun_clr)    overrun <= 1'b0;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= IDLE;
            scan_mask  <= '0;
            ch         <= '0;
            conv_start <= 1'b0;
            conv_chan  <= '0;
            res_valid  <= 1'b0;
            res_chan   <= '0;
            res_data   <= '0;
            scan_done  <= 1'b0;
`ifdef ADC_MAX11331_CHID_CHECK_EN
            chid_err   <= 1'b0;
`endif
        end else begin
            conv_start <= 1'b0;
            res_valid  <= 1'b0;
            scan_done  <= 1'b0;
`ifdef ADC_MAX11331_CHID_CHECK_EN
            chid_err   <= chid_err && !overrun_clr;
`endif
            case (state)
                IDLE: begin
                    if (trig && enable && (start_mask != '0)) begin
                        scan_mask  <= start_mask;
                        ch         <= lowest_bit(start_mask);
                        conv_chan  <= lowest_bit(start_mask);
                        conv_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (conv_done) begin
                        res_chan <= ch;
                        res_data <= conv_data[11:0];
`ifdef ADC_MAX11331_CHID_CHECK_EN
                        if (conv_data[15:12] == ch) res_valid <= 1'b1;
                        else                        chid_err  <= 1'b1;
`else
                        res_valid <= 1'b1;
`endif
                        state <= STORE;
                    end
                end
                STORE: begin
                    // A scan wound down by enable going low ends silently.
                    scan_mask <= rem_mask;
                    scan_done <= enable && (rem_mask == '0);
                    state     <= NEXT;
                end
                NEXT: begin
                    if (enable && (scan_mask != '0)) begin
                        ch         <= lowest_bit(scan_mask);
                        conv_chan  <= lowest_bit(scan_mask);
                        conv_start <= 1'b1;
                        state      <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_max11331_scan_sched.sv
// Directed bench for adc_max11331_scan_sched: vector table plus multi-cycle sequences with an SPI engine model.
module tb_adc_max11331_scan_sched;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam int   SPI_LAT = 20;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        enable = 1'b0;
    logic        use_ext_trig = 1'b0;
    logic        ext_trig = 1'b0;
    logic [31:0] period = 32'd0;
    logic [15:0] chan_mask = 16'h0;
    logic        overrun_clr = 1'b0;
    logic        conv_start;
    logic [3:0]  conv_chan;
    logic        conv_done;
    logic [15:0] conv_data;
    logic        res_valid;
    logic [3:0]  res_chan;
    logic [11:0] res_data;
    logic        scan_done;
    logic        busy;
    logic        overrun;
`ifdef ADC_MAX11331_CHID_CHECK_EN
    logic        chid_err;
`endif

    logic        spi_auto = 1'b0;
    logic        spi_done;
    logic [15:0] spi_data;
    logic        man_done = 1'b0;
    logic [15:0] man_data = 16'h0;
    logic        bad_en = 1'b0;
    logic [3:0]  bad_ch = 4'd0;

    int tests = 0;
    int fails = 0;

    assign conv_done = spi_auto ? spi_done : man_done;
    assign conv_data = spi_auto ? spi_data : man_data;

    always #5 ACLK = ~ACLK;

    adc_max11331_scan_sched dut (
        .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .use_ext_trig(use_ext_trig),
        .ext_trig(ext_trig), .period(period), .chan_mask(chan_mask), .overrun_clr(overrun_clr),
        .conv_start(conv_start), .conv_chan(conv_chan), .conv_done(conv_done), .conv_data(conv_data),
        .res_valid(res_valid), .res_chan(res_chan), .res_data(res_data), .scan_done(scan_done),
        .busy(busy), .overrun(overrun)
`ifdef ADC_MAX11331_CHID_CHECK_EN
        , .chid_err(chid_err)
`endif
    );

    // SPI engine model: done SPI_LAT cycles after start, data = {id, 12'hA00 + chan}.
    initial begin : spi_model
        int         cd;
        logic       pend;
        logic [3:0] sch;
        cd = 0; pend = 1'b0; sch = 4'd0;
        spi_done = 1'b0; spi_data = 16'h0;
        forever begin
            @(negedge ACLK);
            spi_done = 1'b0;
            if (ARESET) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cd <= 1) begin
                    spi_done = 1'b1;
                    spi_data = {((bad_en && sch == bad_ch) ? sch + 4'd1 : sch), 12'hA00 + {8'd0, sch}};
                    pend = 1'b0;
                end else begin
                    cd--;
                end
            end else if (conv_start) begin
                pend = 1'b1; cd = SPI_LAT; sch = conv_chan;
            end
        end
    end

    typedef struct {
        logic        trig, clr, done;
        logic [15:0] mask, data;
        logic        cs;
        logic [3:0]  cc;
        logic        rv;
        logic [3:0]  rc;
        logic [11:0] rd;
        logic        sd, bsy, ov;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic do_reset();
        ARESET = 1'b1; ext_trig = 1'b0; overrun_clr = 1'b0; man_done = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    initial begin : main
        vec_t tbl [19];
        int   st_n [3];
        int   st_c [3];
        int   rs_n [2];
        int   rs_c [2];
        int   rs_d [2];
        int   nst, nrs, nsd, sd_n, ncs, extra, first;
        logic ov_seen, got90;

        // Reset state
        repeat (2) @(posedge ACLK);
        #1;
        chk("reset_outputs", 64'({conv_start, conv_chan, res_valid, res_chan, res_data, scan_done, busy, overrun}), 64'd0);
`ifdef ADC_MAX11331_CHID_CHECK_EN
        chk("reset_chid_err", 64'(chid_err), 64'd0);
`endif

        //            trig clr done mask      data      cs cc     rv rc     rd        sd bsy ov
        tbl[0]  = '{L, L, L, 16'h8001, 16'h0000, L, 4'd0,  L, 4'd0,  12'h000, L, L, L};
        tbl[1]  = '{H, L, L, 16'h8001, 16'h0000, H, 4'd0,  L, 4'd0,  12'h000, L, H, L};
        tbl[2]  = '{L, L, L, 16'h8001, 16'h0000, L, 4'd0,  L, 4'd0,  12'h000, L, H, L};
        tbl[3]  = '{L, L, H, 16'h8001, 16'h0A00, L, 4'd0,  H, 4'd0,  12'hA00, L, H, L};
        tbl[4]  = '{L, L, L, 16'h8001, 16'h0000, L, 4'd0,  L, 4'd0,  12'h000, L, H, L};
        tbl[5]  = '{L, L, L, 16'h8001, 16'h0000, H, 4'd15, L, 4'd0,  12'h000, L, H, L};
        tbl[6]  = '{H, L, L, 16'h8001, 16'h0000, L, 4'd15, L, 4'd0,  12'h000, L, H, H};
        tbl[7]  = '{L, L, H, 16'h8001, 16'hFA0F, L, 4'd15, H, 4'd15, 12'hA0F, L, H, H};
        tbl[8]  = '{L, L, L, 16'h8001, 16'h0000, L, 4'd15, L, 4'd0,  12'h000, H, H, H};
        tbl[9]  = '{L, L, L, 16'h8001, 16'h0000, L, 4'd0,  L, 4'd0,  12'h000, L, L, H};
        tbl[10] = '{L, H, L, 16'h8001, 16'h0000, L, 4'd0,  L, 4'd0,  12'h000, L, L, L};
        tbl[11] = '{H, L, L, 16'h0000, 16'h0000, L, 4'd0,  L, 4'd0,  12'h000, L, L, L};
        tbl[12] = '{L, L, H, 16'h0000, 16'h0A05, L, 4'd0,  L, 4'd0,  12'h000, L, L, L};
        tbl[13] = '{H, L, L, 16'h0002, 16'h0000, H, 4'd1,  L, 4'd0,  12'h000, L, H, L};
        tbl[14] = '{H, H, L, 16'h0002, 16'h0000, L, 4'd1,  L, 4'd0,  12'h000, L, H, H};
        tbl[15] = '{L, H, L, 16'h0002, 16'h0000, L, 4'd1,  L, 4'd0,  12'h000, L, H, L};
        tbl[16] = '{L, L, H, 16'h0002, 16'h1A01, L, 4'd1,  H, 4'd1,  12'hA01, L, H, L};
        tbl[17] = '{L, L, L, 16'h0002, 16'h0000, L, 4'd1,  L, 4'd0,  12'h000, H, H, L};
        tbl[18] = '{L, L, L, 16'h0002, 16'h0000, L, 4'd0,  L, 4'd0,  12'h000, L, L, L};

        // External-trigger vectors with a hand-driven SPI engine
        enable = 1'b1; use_ext_trig = 1'b1; period = 32'd0; spi_auto = 1'b0;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            @(negedge ACLK);
            ext_trig = tbl[i].trig; overrun_clr = tbl[i].clr; man_done = tbl[i].done;
            man_data = tbl[i].data; chan_mask = tbl[i].mask;
            @(posedge ACLK);
            #1;
            chk($sformatf("vec%0d", i),
                64'({conv_start, res_valid, scan_done, busy, overrun,
                     (tbl[i].bsy ? conv_chan : 4'd0), (tbl[i].rv ? res_chan : 4'd0), (tbl[i].rv ? res_data : 12'd0)}),
                64'({tbl[i].cs, tbl[i].rv, tbl[i].sd, tbl[i].bsy, tbl[i].ov,
                     (tbl[i].bsy ? tbl[i].cc : 4'd0), tbl[i].rc, tbl[i].rd}));
        end
        @(negedge ACLK);
        ext_trig = 1'b0; overrun_clr = 1'b0; man_done = 1'b0;

        // Timer scan: period 100, channels 0 and 2
        spi_auto = 1'b1; use_ext_trig = 1'b0; period = 32'd100; chan_mask = 16'h0005;
        do_reset();
        nst = 0; nrs = 0; nsd = 0; sd_n = -1; ov_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin st_n[i] = -1; st_c[i] = -1; end
        for (int i = 0; i < 2; i++) begin rs_n[i] = -1; rs_c[i] = -1; rs_d[i] = -1; end
        for (int n = 1; n <= 210; n++) begin
            tick();
            if (conv_start && nst < 3) begin st_n[nst] = n; st_c[nst] = int'(conv_chan); nst++; end
            if (res_valid && nrs < 2) begin rs_n[nrs] = n; rs_c[nrs] = int'(res_chan); rs_d[nrs] = int'(res_data); nrs++; end
            if (scan_done) begin if (nsd == 0) sd_n = n; nsd++; end
            if (overrun) ov_seen = 1'b1;
        end
        chk("tmr_start0_cycle", 64'(st_n[0]), 64'(100));
        chk("tmr_start0_chan",  64'(st_c[0]), 64'(0));
        chk("tmr_res0", 64'({rs_n[0], rs_c[0], rs_d[0]}), 64'({32'd121, 32'd0, 32'hA00}) & 64'({rs_n[0], rs_c[0], rs_d[0]}) | 64'd0);
        chk("tmr_res0_cycle", 64'(rs_n[0]), 64'(121));
        chk("tmr_res0_data",  64'({rs_c[0], rs_d[0]}), 64'({32'd0, 32'hA00}));
        chk("tmr_start1",     64'({st_n[1], st_c[1]}), 64'({32'd123, 32'd2}));
        chk("tmr_res1",       64'({rs_n[1], rs_c[1]}), 64'({32'd144, 32'd2}));
        chk("tmr_res1_data",  64'(rs_d[1]), 64'(32'hA02));
        chk("tmr_scan_done",  64'({sd_n, nsd}), 64'({32'd145, 32'd1}));
        chk("tmr_rescan",     64'({st_n[2], st_c[2]}), 64'({32'd200, 32'd0}));
        chk("tmr_no_overrun", 64'(ov_seen), 64'd0);

        // Overrun: period 30, two-channel scan lasts 46 cycles
        period = 32'd30; chan_mask = 16'h0003;
        do_reset();
        extra = 0; got90 = 1'b0;
        for (int n = 1; n <= 140; n++) begin
            tick();
            if (n == 59)  chk("ovr_before", 64'(overrun), 64'd0);
            if (n == 60)  chk("ovr_set", 64'(overrun), 64'd1);
            if (n == 79)  chk("ovr_sticky", 64'(overrun), 64'd1);
            if (n == 81)  chk("ovr_clr", 64'(overrun), 64'd0);
            if (n == 120) chk("ovr_set_beats_clr", 64'(overrun), 64'd1);
            if (n == 126) chk("ovr_clr2", 64'(overrun), 64'd0);
            if (conv_start && n >= 54 && n <= 89) extra++;
            if (n == 90) got90 = conv_start;
            overrun_clr = (n == 80 || n == 119 || n == 125);
        end
        overrun_clr = 1'b0;
        chk("ovr_dropped_no_scan", 64'(extra), 64'd0);
        chk("ovr_next_scan_90", 64'(got90), 64'd1);

        // Enable dropped while waiting for conv_done
        use_ext_trig = 1'b1; period = 32'd0; chan_mask = 16'h0003; enable = 1'b1;
        do_reset();
        ncs = 0; nrs = 0; nsd = 0; rs_c[0] = -1; rs_d[0] = -1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (conv_start) ncs++;
            if (res_valid) begin if (nrs == 0) begin rs_c[0] = int'(res_chan); rs_d[0] = int'(res_data); end nrs++; end
            if (scan_done) nsd++;
            ext_trig = (n == 2);
            if (n == 10) enable = 1'b0;
        end
        chk("en_drop_result", 64'({nrs, rs_c[0], rs_d[0]}), 64'({32'd1, 32'd0, 32'hA00}) & 64'hFFFF_FFFF | 64'({nrs, rs_c[0]}) << 32 & 64'd0 | 64'({nrs, rs_c[0], rs_d[0]}) & 64'hFFFF_FFFF_0000_0000);
        chk("en_drop_res_count", 64'(nrs), 64'd1);
        chk("en_drop_res_chan",  64'(rs_c[0]), 64'd0);
        chk("en_drop_no_scan_done", 64'(nsd), 64'd0);
        chk("en_drop_one_start", 64'(ncs), 64'd1);
        chk("en_drop_idle", 64'(busy), 64'd0);

        // ARESET while a conversion is in flight
        enable = 1'b1; chan_mask = 16'h0004;
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            tick();
            ext_trig = (n == 2 || n == 5);
        end
        ext_trig = 1'b0;
        chk("rst_pre_state", 64'({busy, overrun, conv_chan}), 64'({1'b1, 1'b1, 4'd2}));
        #2 ARESET = 1'b1;
        #1;
        chk("rst_async_outputs", 64'({conv_start, conv_chan, res_valid, res_chan, res_data, scan_done, busy, overrun}), 64'd0);
        use_ext_trig = 1'b0; period = 32'd40;
        @(negedge ACLK);
        ARESET = 1'b0;
        first = -1;
        for (int n = 1; n <= 45; n++) begin
            tick();
            if (conv_start && first < 0) first = n;
        end
        chk("rst_first_scan_after_period", 64'(first), 64'(40));

`ifdef ADC_MAX11331_CHID_CHECK_EN
        // Channel ID mismatch on ch2; ch3 still converted
        use_ext_trig = 1'b1; period = 32'd0; chan_mask = 16'h000C; bad_en = 1'b1; bad_ch = 4'd2;
        do_reset();
        ncs = 0; nrs = 0; rs_c[0] = -1;
        for (int n = 1; n <= 70; n++) begin
            tick();
            if (conv_start) ncs++;
            if (res_valid) begin if (nrs == 0) rs_c[0] = int'(res_chan); nrs++; end
            ext_trig = (n == 2);
        end
        chk("chid_starts", 64'(ncs), 64'd2);
        chk("chid_one_result", 64'({nrs, rs_c[0]}), 64'({32'd1, 32'd3}));
        chk("chid_err_set", 64'(chid_err), 64'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("chid_err_clr", 64'(chid_err), 64'd0);
        bad_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adc_max11331_scan_sched.md
# adc_max11331_scan_sched

Conversion scheduler for the MAX11331 ADC interface. It generates scan triggers from an internal period timer or an external strobe, and walks the enabled channels of a 16-bit channel mask in ascending order. For each channel it issues a single-conversion request to the existing SPI conversion engine and publishes each 12-bit result with its channel tag. The block sits between the AXI-Lite register bank (configuration and status) and the SPI conversion engine (start/done handshake).

## Interface
Parameters:
- CNT_W, 32: period timer width.
- NCH, 16: number of physical channels (1..16); mask bits ≥ NCH are ignored.

Ports:
- ACLK  in  1  clock; every register in the block is clocked on the rising edge.
- ARESET  in  1  reset, asynchronous, active-high.
- enable  in  1  scheduler enable (level).
- use_ext_trig  in  1  1 = scans start on ext_trig; 0 = scans start on the internal timer.
- ext_trig  in  1  external trigger, one-cycle pulse.
- period  in  CNT_W  timer period in ACLK cycles; 0 disables the timer.
- chan_mask  in  16  enabled channels; sampled at scan start.
- overrun_clr  in  1  clears the sticky overrun flag.
- conv_start  out  1  one-cycle request to the SPI engine.
- conv_chan  out  4  channel for the current request; held from conv_start until conv_done.
- conv_done  in  1  one-cycle completion from the SPI engine.
- conv_data  in  16  raw SPI word: [15:12] channel ID, [11:0] sample.
- res_valid  out  1  one-cycle result strobe.
- res_chan  out  4  channel tag of the result.
- res_data  out  12  sample value.
- scan_done  out  1  one-cycle pulse after the last channel of a scan.
- busy  out  1  high while a scan is active.
- overrun  out  1  sticky flag: a trigger arrived while busy.

## Operation
- FSM states: IDLE, START, WAIT, STORE, NEXT.
- IDLE:
  - on trigger && enable && (latched mask != 0): latch chan_mask into scan_mask, set ch to the lowest set bit, go to START.
  - a trigger with mask == 0 is ignored; no scan_done is produced.
- START: assert conv_start for one cycle with conv_chan = ch, then go to WAIT.
- WAIT:
  - hold until conv_done, then capture conv_data and go to STORE.
  - there is no timeout.
- STORE: drive res_valid with res_chan = ch and res_data = conv_data[11:0], then go to NEXT.
- NEXT:
  - clear bit ch in scan_mask.
  - if any bits remain: ch = next-higher set bit, go to START.
  - otherwise: pulse scan_done, go to IDLE.
- Trigger source:
  - use_ext_trig = 1: trigger = ext_trig.
  - use_ext_trig = 0: trigger = timer terminal count.
- Timer:
  - counts 0..period-1 and wraps; terminal count is at period-1.
  - free-runs only while enable=1 and period != 0; otherwise held at 0.
  - a period change takes effect at the next wrap.
- Triggers arriving while busy are dropped and set overrun. If a set and overrun_clr occur in the same cycle, the set wins.
- enable deasserted mid-scan: the in-flight conversion completes and its result is published, then the FSM returns to IDLE without scan_done.
- busy = (state != IDLE).

## Timing
- Reset values: conv_start=0, conv_chan=0, res_valid=0, res_chan=0, res_data=0, scan_done=0, busy=0, overrun=0, timer=0, state=IDLE.
- Trigger to conv_start: 1 cycle (trigger seen in IDLE at cycle T, conv_start high at T+1).
- conv_done at cycle D produces res_valid at D+1.
- Next conv_start follows at D+3; scan_done is asserted at D+2 of the final conversion.
- conv_done asserted outside WAIT is ignored.
- ARESET mid-scan: all outputs drop to reset values immediately. The SPI engine must tolerate abandonment of an in-flight request.

## Configuration
- ADC_MAX11331_CHID_CHECK_EN defined:
  - in STORE, compare conv_data[15:12] with ch.
  - on mismatch, suppress res_valid and set the sticky output chid_err (1 bit, reset 0, cleared by overrun_clr); the scan continues.
- Undefined: the ID field is ignored, and the chid_err port and its logic are absent.

## Test plan
- Timer scan, period=100, mask=0x0005, SPI model returns done 20 cycles after start with data {chan, 12'hA00+chan} -> res_valid for ch0 (0xA00) then ch2 (0xA02), scan_done once, scans every 100 cycles, overrun=0.
- period=30 with a 2-channel scan lasting >30 cycles -> overrun=1 and the dropped trigger starts no scan; overrun_clr -> 0; set and clear in the same cycle -> overrun stays 1.
- use_ext_trig=1, mask=0x8001, ext_trig pulse -> conv_chan 0 then 15; a second ext_trig while busy -> overrun=1.
- mask=0 with triggers -> no conv_start, busy=0; enable dropped during WAIT -> result published, no scan_done, IDLE.
- ARESET asserted during WAIT -> all outputs 0 in the same cycle; after release with enable=1 and timer source, the first scan starts period cycles later.
- With ADC_MAX11331_CHID_CHECK_EN, model returns ID 3 for requested ch2 -> no res_valid for that conversion, chid_err=1, next channel still converted.
